// File: rtl/extreme_detect.sv
// extreme_detect: 3x3x3 DoG strict-extremum detector with border suppression,
// per-octave frame position tracking and a per-frame keypoint count.
// Latency is 3 cycles from in_en to kp_valid/frame_done.
// Optional feature macro: EXTREME_CONTRAST_EN adds the |centre| > CONTRAST_TH
// test in stage 2. When the macro is undefined, stage 2 is a plain register.
module extreme_detect #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int CONTRAST_TH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [7:0]    dout11, dout12, dout13, dout14, dout15,
    input  logic signed [7:0]    dout16, dout17, dout18, dout19,
    input  logic signed [7:0]    dout21, dout22, dout23, dout24, dout25,
    input  logic signed [7:0]    dout26, dout27, dout28, dout29,
    input  logic signed [7:0]    dout31, dout32, dout33, dout34, dout35,
    input  logic signed [7:0]    dout36, dout37, dout38, dout39,
    input  logic                 in_en,
    input  logic                 complete1,
    output logic                 kp_valid,
    output logic [XW-1:0]        kp_x,
    output logic [YW-1:0]        kp_y,
    output logic signed [7:0]    kp_val,
    output logic                 kp_min,
    output logic                 kp_oct,
    output logic                 frame_done,
    output logic [15:0]          kp_count
);

    localparam logic [XW-1:0] X_LAST0 = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_LAST1 = XW'(IMG_W / 2 - 1);
    localparam logic [YW-1:0] Y_LAST0 = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_LAST1 = YW'(IMG_H / 2 - 1);
    localparam int unsigned   CTR     = 13;  // flat index of dout25

    logic signed [7:0] win [27];

    // Position tracking and octave change detect
    logic [XW-1:0] px_q, px_d, px_eff, x_last;
    logic [YW-1:0] py_q, py_d, py_eff, y_last;
    logic          comp_q, comp_d, chg;
    logic [15:0]   cnt_q, cnt_d, cnt_inc, cnt_next;

    // Stage 1
    logic                 v1_q, v1_d, gta_q, gta_d, gtb_q, gtb_d, lta_q, lta_d, ltb_q, ltb_d;
    logic signed [7:0]    val1_q, val1_d;
    logic [XW-1:0]        x1_q, x1_d;
    logic [YW-1:0]        y1_q, y1_d;
    logic                 oct1_q, oct1_d, el1_q, el1_d, last1_q, last1_d;

    // Stage 2
    logic                 v2_q, v2_d, gt2_q, gt2_d, lt2_q, lt2_d;
    logic signed [7:0]    val2_q, val2_d;
    logic [XW-1:0]        x2_q, x2_d;
    logic [YW-1:0]        y2_q, y2_d;
    logic                 oct2_q, oct2_d, el2_q, el2_d, last2_q, last2_d;
`ifdef EXTREME_CONTRAST_EN
    logic                 pass2_q, pass2_d;
    logic [8:0]           val9, mag9;
`endif

    // Stage 3 (outputs)
    logic                 hit;
    logic                 kp_valid_q, kp_valid_d, kp_min_q, kp_min_d, kp_oct_q, kp_oct_d;
    logic [XW-1:0]        kp_x_q, kp_x_d;
    logic [YW-1:0]        kp_y_q, kp_y_d;
    logic signed [7:0]    kp_val_q, kp_val_d;
    logic                 frame_done_q, frame_done_d;
    logic [15:0]          kp_count_q, kp_count_d;

    // Gather window, track position, run the three pipeline stages
    always_comb begin
        win = '{dout11, dout12, dout13, dout14, dout15, dout16, dout17, dout18, dout19,
                dout21, dout22, dout23, dout24, dout25, dout26, dout27, dout28, dout29,
                dout31, dout32, dout33, dout34, dout35, dout36, dout37, dout38, dout39};

        // An octave switch restarts the frame; a window in the same cycle lands at (0,0)
        chg    = complete1 != comp_q;
        comp_d = complete1;
        x_last = complete1 ? X_LAST1 : X_LAST0;
        y_last = complete1 ? Y_LAST1 : Y_LAST0;
        px_eff = chg ? '0 : px_q;
        py_eff = chg ? '0 : py_q;
        px_d   = px_eff;
        py_d   = py_eff;
        if (in_en) begin
            if (px_eff == x_last) begin
                px_d = '0;
                py_d = (py_eff == y_last) ? '0 : py_eff + YW'(1);
            end else begin
                px_d = px_eff + XW'(1);
            end
        end

        // Stage 1: two 13-compare partial ANDs per direction
        gta_d = 1'b1;
        lta_d = 1'b1;
        gtb_d = 1'b1;
        ltb_d = 1'b1;
        for (int unsigned i = 0; i < CTR; i++) begin
            gta_d = gta_d & (win[CTR] > win[i]);
            lta_d = lta_d & (win[CTR] < win[i]);
        end
        for (int unsigned i = CTR + 1; i < 27; i++) begin
            gtb_d = gtb_d & (win[CTR] > win[i]);
            ltb_d = ltb_d & (win[CTR] < win[i]);
        end
        v1_d    = in_en;
        val1_d  = win[CTR];
        x1_d    = px_eff - XW'(1);
        y1_d    = py_eff - YW'(1);
        oct1_d  = complete1;
        el1_d   = (px_eff >= XW'(2)) && (py_eff >= YW'(2));
        last1_d = (px_eff == x_last) && (py_eff == y_last);

        // Stage 2: combine partials, optional contrast check
        v2_d    = v1_q;
        gt2_d   = gta_q & gtb_q;
        lt2_d   = lta_q & ltb_q;
        val2_d  = val1_q;
        x2_d    = x1_q;
        y2_d    = y1_q;
        oct2_d  = oct1_q;
        el2_d   = el1_q;
        last2_d = last1_q;
`ifdef EXTREME_CONTRAST_EN
        val9    = {val1_q[7], val1_q};
        mag9    = val9[8] ? (9'd0 - val9) : val9;
        pass2_d = mag9 > 9'(CONTRAST_TH);
        hit     = v2_q & el2_q & (gt2_q | lt2_q) & pass2_q;
`else
        hit     = v2_q & el2_q & (gt2_q | lt2_q);
`endif

        // Stage 3: registered outputs, held between keypoints
        kp_valid_d   = hit;
        kp_x_d       = hit ? x2_q   : kp_x_q;
        kp_y_d       = hit ? y2_q   : kp_y_q;
        kp_val_d     = hit ? val2_q : kp_val_q;
        kp_min_d     = hit ? lt2_q  : kp_min_q;
        kp_oct_d     = hit ? oct2_q : kp_oct_q;
        frame_done_d = v2_q & last2_q;

        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        cnt_next   = hit ? cnt_inc : cnt_q;
        kp_count_d = kp_count_q;
        cnt_d      = cnt_next;
        if (v2_q & last2_q) begin
            kp_count_d = cnt_next;
            cnt_d      = '0;
        end
        if (chg) cnt_d = '0;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            px_q <= '0; py_q <= '0; comp_q <= 1'b0; cnt_q <= '0;
            v1_q <= 1'b0; gta_q <= 1'b0; gtb_q <= 1'b0; lta_q <= 1'b0; ltb_q <= 1'b0;
            val1_q <= '0; x1_q <= '0; y1_q <= '0; oct1_q <= 1'b0; el1_q <= 1'b0; last1_q <= 1'b0;
            v2_q <= 1'b0; gt2_q <= 1'b0; lt2_q <= 1'b0;
            val2_q <= '0; x2_q <= '0; y2_q <= '0; oct2_q <= 1'b0; el2_q <= 1'b0; last2_q <= 1'b0;
`ifdef EXTREME_CONTRAST_EN
            pass2_q <= 1'b0;
`endif
            kp_valid_q <= 1'b0; kp_x_q <= '0; kp_y_q <= '0; kp_val_q <= '0;
            kp_min_q <= 1'b0; kp_oct_q <= 1'b0; frame_done_q <= 1'b0; kp_count_q <= '0;
        end else begin
            px_q <= px_d; py_q <= py_d; comp_q <= comp_d; cnt_q <= cnt_d;
            v1_q <= v1_d; gta_q <= gta_d; gtb_q <= gtb_d; lta_q <= lta_d; ltb_q <= ltb_d;
            val1_q <= val1_d; x1_q <= x1_d; y1_q <= y1_d; oct1_q <= oct1_d; el1_q <= el1_d;
            last1_q <= last1_d;
            v2_q <= v2_d; gt2_q <= gt2_d; lt2_q <= lt2_d;
            val2_q <= val2_d; x2_q <= x2_d; y2_q <= y2_d; oct2_q <= oct2_d; el2_q <= el2_d;
            last2_q <= last2_d;
`ifdef EXTREME_CONTRAST_EN
            pass2_q <= pass2_d;
`endif
            kp_valid_q <= kp_valid_d; kp_x_q <= kp_x_d; kp_y_q <= kp_y_d; kp_val_q <= kp_val_d;
            kp_min_q <= kp_min_d; kp_oct_q <= kp_oct_d; frame_done_q <= frame_done_d;
            kp_count_q <= kp_count_d;
        end
    end

    assign kp_valid   = kp_valid_q;
    assign kp_x       = kp_x_q;
    assign kp_y       = kp_y_q;
    assign kp_val     = kp_val_q;
    assign kp_min     = kp_min_q;
    assign kp_oct     = kp_oct_q;
    assign frame_done = frame_done_q;
    assign kp_count   = kp_count_q;

endmodule

// File: tb/tb_extreme_detect.sv
// Scoreboard bench for extreme_detect: the stimulus process runs a
// behavioural model and queues expected output events; a negedge monitor
// matches every DUT output event against the queue.
module tb_extreme_detect;
    localparam int W0 = 8;
    localparam int H0 = 6;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int TH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, in_en, complete1;
    logic signed [7:0]    win [27];
    logic                 kp_valid, kp_min, kp_oct, frame_done;
    logic [XW-1:0]        kp_x;
    logic [YW-1:0]        kp_y;
    logic signed [7:0]    kp_val;
    logic [15:0]          kp_count;

    extreme_detect #(.IMG_W(W0), .IMG_H(H0), .XW(XW), .YW(YW), .CONTRAST_TH(TH)) dut (
        .clk(clk), .rst(rst),
        .dout11(win[0]),  .dout12(win[1]),  .dout13(win[2]),  .dout14(win[3]),
        .dout15(win[4]),  .dout16(win[5]),  .dout17(win[6]),  .dout18(win[7]),
        .dout19(win[8]),
        .dout21(win[9]),  .dout22(win[10]), .dout23(win[11]), .dout24(win[12]),
        .dout25(win[13]), .dout26(win[14]), .dout27(win[15]), .dout28(win[16]),
        .dout29(win[17]),
        .dout31(win[18]), .dout32(win[19]), .dout33(win[20]), .dout34(win[21]),
        .dout35(win[22]), .dout36(win[23]), .dout37(win[24]), .dout38(win[25]),
        .dout39(win[26]),
        .in_en(in_en), .complete1(complete1),
        .kp_valid(kp_valid), .kp_x(kp_x), .kp_y(kp_y), .kp_val(kp_val),
        .kp_min(kp_min), .kp_oct(kp_oct), .frame_done(frame_done), .kp_count(kp_count)
    );

    typedef struct {
        int cyc; bit kpv; int x; int y; int val; bit mn; bit oct; bit fd; int cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Model state: position of the newest sample, running count, last octave
    int   mx = 0, my = 0, mcnt = 0;
    bit   m_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every DUT output event must match the queue head due this cycle
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("kp_valid", int'(kp_valid), int'(e.kpv));
            chk("frame_done", int'(frame_done), int'(e.fd));
            if (e.kpv) begin
                chk("kp_x", int'(kp_x), e.x);
                chk("kp_y", int'(kp_y), e.y);
                chk("kp_val", int'(kp_val), e.val);
                chk("kp_min", int'(kp_min), int'(e.mn));
                chk("kp_oct", int'(kp_oct), int'(e.oct));
            end
            if (e.fd) chk("kp_count", int'(kp_count), e.cnt);
        end else if (kp_valid || frame_done) begin
            chk("spurious_output", int'({kp_valid, frame_done}), 0);
        end
    end

    task automatic set_bg(input int v);
        for (int i = 0; i < 27; i++) win[i] = 8'(v);
    endtask

    // Drive one cycle of inputs, update the model, advance to the next cycle
    task automatic step(input bit en, input bit c1);
        int W, H, c, wi;
        bit gt, lt, pass, kp, last;
        in_en = en;
        complete1 = c1;
        W = c1 ? W0 / 2 : W0;
        H = c1 ? H0 / 2 : H0;
        if (c1 != m_prev) begin
            mx = 0; my = 0; mcnt = 0;
        end
        m_prev = c1;
        if (en) begin
            c  = win[13];
            gt = 1'b1;
            lt = 1'b1;
            for (int i = 0; i < 27; i++) begin
                if (i != 13) begin
                    wi = win[i];
                    if (!(c > wi)) gt = 1'b0;
                    if (!(c < wi)) lt = 1'b0;
                end
            end
`ifdef EXTREME_CONTRAST_EN
            pass = ((c < 0) ? -c : c) > TH;
`else
            pass = 1'b1;
`endif
            kp   = (mx >= 2) && (my >= 2) && (gt || lt) && pass;
            last = (mx == W - 1) && (my == H - 1);
            if (kp && mcnt < 65535) mcnt++;
            if (kp || last) q.push_back('{cyc + 3, kp, mx - 1, my - 1, c, lt, c1, last, mcnt});
            if (last) mcnt = 0;
            mx++;
            if (mx == W) begin
                mx = 0;
                my++;
                if (my == H) my = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit c1);
        for (int i = 0; i < n; i++) step(1'b0, c1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_kp_valid"}, int'(kp_valid), 0);
        chk({tag, "_kp_x"}, int'(kp_x), 0);
        chk({tag, "_kp_y"}, int'(kp_y), 0);
        chk({tag, "_kp_val"}, int'(kp_val), 0);
        chk({tag, "_kp_min"}, int'(kp_min), 0);
        chk({tag, "_kp_oct"}, int'(kp_oct), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_kp_count"}, int'(kp_count), 0);
    endtask

    // One-cycle reset: in-flight results are dropped from the expectation queue
    task automatic do_reset(input string tag);
        rst = 1'b1;
        in_en = 1'b0;
        while (q.size() > 0 && q[q.size() - 1].cyc > cyc) void'(q.pop_back());
        mx = 0; my = 0; mcnt = 0; m_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check_zero(tag);
        step(1'b0, complete1);
    endtask

    // Directed octave-0 window content chosen by the newest-sample position
    task automatic frame0_win(input int x, input int y);
        set_bg(1);
        if (x == 5 && y == 3) begin set_bg(0); win[13] = 8'sd10; end
        if (x == 2 && y == 2) begin set_bg(0); win[13] = 8'sd10; win[2] = 8'sd10; end
        if (x == 3 && y == 4) begin set_bg(0); win[13] = -8'sd5; end
        if (x == 1 && y == 3) begin set_bg(0); win[13] = 8'sd20; end
        if (x == 4 && y == 1) begin set_bg(0); win[13] = 8'sd20; end
        if (x == 6 && y == 4) begin set_bg(0); win[13] = -8'sd3; end
        if (x == 2 && y == 5) begin set_bg(0); win[13] = -8'sd128; end
    endtask

    task automatic run_frame0();
        for (int k = 0; k < W0 * H0; k++) begin
            frame0_win(mx, my);
            step(1'b1, 1'b0);
        end
    endtask

    task automatic run_oct1(input int n);
        for (int k = 0; k < n; k++) begin
            set_bg(2);
            if (mx == 2 && my == 2) begin set_bg(0); win[13] = 8'sd50; end
            step(1'b1, 1'b1);
        end
    endtask

    task automatic rand_win();
        int mode, b;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < 27; i++) begin
            if (mode == 0) win[i] = 8'($urandom_range(0, 255));
            else           win[i] = 8'(int'($urandom_range(0, 4)) - 2);
        end
        if (mode == 2) begin
            b = $urandom_range(0, 1);
            win[13] = b ? 8'sd100 : -8'sd100;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_en = 1'b0;
        complete1 = 1'b0;
        set_bg(0);
        @(posedge clk);
        #1;
        do_reset("reset");

        // Octave 0 directed frame: maxima, minima, tie, border, threshold, -128
        run_frame0();
        idle(4, 1'b0);

        // Octave 1 complete frame (12 windows)
        step(1'b0, 1'b1);
        run_oct1(12);
        idle(4, 1'b1);

        // Octave 1 aborted mid-frame by switching back to octave 0
        run_oct1(7);
        idle(4, 1'b1);
        step(1'b0, 1'b0);
        run_frame0();
        idle(4, 1'b0);

        // Random windows with in_en gaps across several frames
        for (int k = 0; k < 320; k++) begin
            rand_win();
            step(($urandom_range(0, 3) != 0), 1'b0);
        end
        idle(4, 1'b0);

        // Reset mid-frame with an eligible extremum in flight
        do_reset("midreset");
        for (int k = 0; k < 20; k++) begin
            set_bg(1);
            if (mx == 3 && my == 2) begin set_bg(0); win[13] = 8'sd60; end
            step(1'b1, 1'b0);
            if (mx == 4 && my == 2) break;
        end
        do_reset("midreset2");
        idle(8, 1'b0);

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
